// File: rtl/mips_check_pkg.sv
// Shared types and default constants for the store-sequence checker.
// The state encoding is visible on the status port, so its values are fixed.
package mips_check_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } check_state_e;

    function automatic logic is_terminal(input check_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/store_exp_table.sv
// Expected-store table: one synchronous write port, one combinational read port.
// Contents are not reset; out-of-range indices read as zero and never write.
module store_exp_table #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 64,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH_I)) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = (raddr < DEPTH_I) ? mem[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/store_sequence_checker.sv
// Compares the processor store bus against a preloaded ordered list of
// expected (address, data) stores and reports pass, fail or timeout.
module store_sequence_checker
    import mips_check_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IDX_W  = $clog2(DEPTH + 1),
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0] pc,
    output logic              done,
    output logic              pass,
    output logic [2:0]        status,
    output logic [IDX_W-1:0]  match_count,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ADDR_W-1:0] fail_pc,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [IDX_W-1:0] DEPTH_I   = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    check_state_e              state_q, state_d;
    logic [IDX_W-1:0]          n_loaded_q, n_loaded_d;
    logic [IDX_W-1:0]          match_q, match_d, match_inc;
    logic [IDX_W-1:0]          fail_idx_q, fail_idx_d;
    logic [ADDR_W-1:0]         fail_pc_q, fail_pc_d;
    logic [CNT_W-1:0]          cycle_q, cycle_d;
    logic                      done_q, pass_q;
    logic                      tbl_we;
    logic [ADDR_W+DATA_W-1:0]  tbl_rdata;
    logic                      store_hit;

    store_exp_table #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ADDR_W + DATA_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (n_loaded_q),
        .wdata ({ld_addr, ld_data}),
        .raddr (match_q),
        .rdata (tbl_rdata)
    );

    // Load handshake: an entry transfers on a rising edge where ld_valid and
    // ld_ready are both high; ld_valid while ld_ready is low is dropped.
    assign ld_ready  = (state_q == ST_LOAD) && (n_loaded_q < DEPTH_I);
    assign store_hit = ({dataadr, writedata} == tbl_rdata);
    assign match_inc = match_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        n_loaded_d = n_loaded_q;
        match_d    = match_q;
        cycle_d    = cycle_q;
        fail_pc_d  = fail_pc_q;
        fail_idx_d = fail_idx_q;
        tbl_we     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (ld_valid && ld_ready) begin
                    tbl_we     = 1'b1;
                    n_loaded_d = n_loaded_q + IDX_W'(1);
                end
                // n_loaded_d so a load in the same cycle as start counts.
                if (start) begin
                    match_d    = '0;
                    cycle_d    = '0;
                    fail_pc_d  = '0;
                    fail_idx_d = '0;
                    state_d    = (n_loaded_d == '0) ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_d = (cycle_q == TIMEOUT_C) ? cycle_q : cycle_q + CNT_W'(1);
                if (memwrite && !store_hit) begin
                    state_d    = ST_FAIL;
                    fail_pc_d  = pc;
                    fail_idx_d = match_q;
                end else if (memwrite && (match_inc == n_loaded_q)) begin
                    match_d = match_inc;
                    state_d = ST_PASS;
                end else begin
                    if (memwrite) begin
                        match_d = match_inc;
                    end
                    if (cycle_d == TIMEOUT_C) begin
                        state_d = ST_TIMEOUT;
                    end
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (start) begin
                    match_d    = '0;
                    cycle_d    = '0;
                    fail_pc_d  = '0;
                    fail_idx_d = '0;
                    state_d    = (n_loaded_q == '0) ? ST_PASS : ST_RUN;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            n_loaded_q <= '0;
            match_q    <= '0;
            cycle_q    <= '0;
            fail_pc_q  <= '0;
            fail_idx_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_loaded_q <= n_loaded_d;
            match_q    <= match_d;
            cycle_q    <= cycle_d;
            fail_pc_q  <= fail_pc_d;
            fail_idx_q <= fail_idx_d;
            done_q     <= is_terminal(state_d);
            pass_q     <= (state_d == ST_PASS);
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign status      = state_q;
    assign match_count = match_q;
    assign fail_idx    = fail_idx_q;
    assign fail_pc     = fail_pc_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_store_sequence_checker.sv
// Directed bench for store_sequence_checker (DEPTH=8, TIMEOUT=16).
// exp_q mirrors the entries the table should hold and drives store replays.
module tb_store_sequence_checker;
    import mips_check_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = $clog2(DEPTH + 1);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    logic              clk;
    logic              reset;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              start;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic [ADDR_W-1:0] pc;
    logic              done;
    logic              pass;
    logic [2:0]        status;
    logic [IDX_W-1:0]  match_count;
    logic [IDX_W-1:0]  fail_idx;
    logic [ADDR_W-1:0] fail_pc;
    logic [CNT_W-1:0]  cycle_count;

    int checks   = 0;
    int failures = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    store_sequence_checker #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .start       (start),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .pc          (pc),
        .done        (done),
        .pass        (pass),
        .status      (status),
        .match_count (match_count),
        .fail_idx    (fail_idx),
        .fail_pc     (fail_pc),
        .cycle_count (cycle_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.delete();
    endtask

    // Drivers
    task automatic load_entry(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        if (exp_q.size() < DEPTH) exp_q.push_back({a, d});
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic drive_store(input logic [ADDR_W+DATA_W-1:0] e, input logic [ADDR_W-1:0] p);
        memwrite  = 1'b1;
        dataadr   = e[ADDR_W+DATA_W-1:DATA_W];
        writedata = e[DATA_W-1:0];
        pc        = p;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_status",   64'(status),      64'(ST_LOAD));
        check("rst_ld_ready", 64'(ld_ready),    64'd1);
        check("rst_done",     64'(done),        64'd0);
        check("rst_pass",     64'(pass),        64'd0);
        check("rst_match",    64'(match_count), 64'd0);
        check("rst_cycle",    64'(cycle_count), 64'd0);
        reset = 1'b1;

        // Two matching stores in order
        load_entry(32'h54, 32'h7);
        load_entry(32'h50, 32'h7);
        check("t1_ld_ready", 64'(ld_ready), 64'd1);
        go();
        check("t1_run", 64'(status), 64'(ST_RUN));
        drive_store(exp_q[0], 32'h40);
        check("t1_match1", 64'(match_count), 64'd1);
        check("t1_still_run", 64'(status), 64'(ST_RUN));
        drive_store(exp_q[1], 32'h44);
        check("t1_pass_state", 64'(status), 64'(ST_PASS));
        check("t1_done", 64'(done), 64'd1);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_match2", 64'(match_count), 64'd2);
        check("t1_cycle", 64'(cycle_count), 64'd2);
        drive_store({32'h99, 32'h99}, 32'h48);
        check("t1_hold_state", 64'(status), 64'(ST_PASS));
        check("t1_hold_match", 64'(match_count), 64'd2);

        // Re-run from PASS with the retained table
        go();
        check("t6_run", 64'(status), 64'(ST_RUN));
        check("t6_match_clr", 64'(match_count), 64'd0);
        check("t6_cycle_clr", 64'(cycle_count), 64'd0);
        check("t6_done_clr", 64'(done), 64'd0);
        check("t6_pass_clr", 64'(pass), 64'd0);
        foreach (exp_q[i]) drive_store(exp_q[i], 32'h100 + 32'(i * 4));
        check("t6_pass_state", 64'(status), 64'(ST_PASS));
        check("t6_match", 64'(match_count), 64'd2);

        // Data mismatch on the first store
        do_reset();
        load_entry(32'h54, 32'h7);
        go();
        drive_store({32'h54, 32'h8}, 32'h3C);
        check("t2_fail_state", 64'(status), 64'(ST_FAIL));
        check("t2_fail_idx", 64'(fail_idx), 64'd0);
        check("t2_fail_pc", 64'(fail_pc), 64'h3C);
        check("t2_done", 64'(done), 64'd1);
        check("t2_pass", 64'(pass), 64'd0);

        // Timeout with no stores
        do_reset();
        load_entry(32'h100, 32'hAB);
        go();
        repeat (15) tick();
        check("t3_run_at_15", 64'(status), 64'(ST_RUN));
        check("t3_cycle_15", 64'(cycle_count), 64'd15);
        tick();
        check("t3_timeout", 64'(status), 64'(ST_TIMEOUT));
        check("t3_cycle_16", 64'(cycle_count), 64'd16);
        check("t3_done", 64'(done), 64'd1);
        check("t3_pass", 64'(pass), 64'd0);
        tick();
        check("t3_cycle_hold", 64'(cycle_count), 64'd16);

        // Completing match on the timeout cycle wins
        go();
        check("t3b_cycle_clr", 64'(cycle_count), 64'd0);
        repeat (15) tick();
        drive_store(exp_q[0], 32'h70);
        check("t3b_pass_state", 64'(status), 64'(ST_PASS));
        check("t3b_cycle", 64'(cycle_count), 64'd16);

        // Mismatch on the timeout cycle gives FAIL
        go();
        repeat (15) tick();
        drive_store({32'h100, 32'hAC}, 32'h80);
        check("t3c_fail_state", 64'(status), 64'(ST_FAIL));
        check("t3c_fail_pc", 64'(fail_pc), 64'h80);

        // Nine loads into an eight-entry table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("t4_ld_ready_full", 64'(ld_ready), 64'd0);
            load_entry(32'h200 + 32'(i * 4), 32'(i + 1));
        end
        go();
        for (int i = 0; i < 7; i++) drive_store(exp_q[i], 32'h300);
        check("t4_run_at_7", 64'(status), 64'(ST_RUN));
        drive_store(exp_q[7], 32'h304);
        check("t4_pass_state", 64'(status), 64'(ST_PASS));
        check("t4_match", 64'(match_count), 64'd8);

        // Start with an empty table
        do_reset();
        go();
        check("t4b_pass_state", 64'(status), 64'(ST_PASS));
        check("t4b_done", 64'(done), 64'd1);
        check("t4b_pass", 64'(pass), 64'd1);
        check("t4b_match", 64'(match_count), 64'd0);

        // Load and start in the same cycle
        do_reset();
        ld_valid = 1'b1; ld_addr = 32'h60; ld_data = 32'h5A; start = 1'b1;
        exp_q.push_back({32'h60, 32'h5A});
        tick();
        ld_valid = 1'b0; start = 1'b0;
        check("t7_run", 64'(status), 64'(ST_RUN));
        drive_store(exp_q[0], 32'h10);
        check("t7_pass_state", 64'(status), 64'(ST_PASS));

        // Asynchronous reset mid-RUN
        do_reset();
        load_entry(32'h54, 32'h7);
        load_entry(32'h50, 32'h7);
        go();
        drive_store(exp_q[0], 32'h20);
        check("t5_match_pre", 64'(match_count), 64'd1);
        reset = 1'b0;
        #1;
        check("t5_status", 64'(status), 64'(ST_LOAD));
        check("t5_match", 64'(match_count), 64'd0);
        check("t5_cycle", 64'(cycle_count), 64'd0);
        check("t5_ld_ready", 64'(ld_ready), 64'd1);
        check("t5_done", 64'(done), 64'd0);
        check("t5_fail_pc", 64'(fail_pc), 64'd0);
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_sequence_checker.md
STORE_SEQUENCE_CHECKER -- requirements
Module: store_sequence_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning store data width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning store address and PC width.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning expected-store table entries; IDX_W = $clog2(DEPTH+1).
REQ-004 The block SHALL have parameter TIMEOUT, default 1024, meaning RUN cycles allowed; CNT_W = $clog2(TIMEOUT+1).
REQ-005 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-006 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port ld_valid  in  1  table-load strobe.
REQ-008 The block SHALL have ports ld_addr  in  ADDR_W and ld_data  in  DATA_W, the expected store entry.
REQ-009 The block SHALL have port ld_ready  out  1  table accepting loads.
REQ-010 The block SHALL have port start  in  1  begin or re-run the check.
REQ-011 The block SHALL have ports memwrite  in  1, dataadr  in  ADDR_W, writedata  in  DATA_W and pc  in  ADDR_W, the processor store bus.
REQ-012 The block SHALL have ports done  out  1 and pass  out  1, the verdict.
REQ-013 The block SHALL have port status  out  3  current state code.
REQ-014 The block SHALL have ports match_count  out  IDX_W, fail_idx  out  IDX_W, fail_pc  out  ADDR_W and cycle_count  out  CNT_W.

Function
REQ-015 The FSM SHALL have states LOAD, RUN, PASS, FAIL and TIMEOUT; PASS, FAIL and TIMEOUT are terminal.
REQ-016 In LOAD, ld_ready SHALL be 1 while n_loaded<DEPTH; ld_valid then writes table[n_loaded] and increments n_loaded.
REQ-017 Loads at n_loaded==DEPTH or outside LOAD SHALL be ignored.
REQ-018 start in LOAD SHALL enter RUN next cycle; ld_valid asserted with start in the same cycle is captured first.
REQ-019 start with n_loaded==0 SHALL go directly to PASS.
REQ-020 In RUN, cycle_count SHALL increment each cycle, saturating at TIMEOUT.
REQ-021 In RUN, on memwrite, {dataadr,writedata}==table[match_count] SHALL increment match_count, and the block enters PASS when the new count equals n_loaded.
REQ-022 In RUN, a memwrite mismatch SHALL enter FAIL next cycle, capturing fail_pc=pc and fail_idx=match_count.
REQ-023 In RUN, cycle_count reaching TIMEOUT without completion SHALL enter TIMEOUT; a completing match in that same cycle gives PASS, and a mismatch gives FAIL.
REQ-024 done SHALL be 1 in the terminal states, and pass SHALL be 1 only in PASS; both are registered.
REQ-025 Terminal states SHALL hold until start, which re-enters RUN with match_count, cycle_count, fail_pc and fail_idx cleared and the table retained.
REQ-026 memwrite outside RUN SHALL be ignored.

Reset
REQ-027 Asserted reset SHALL immediately force LOAD, n_loaded=0, ld_ready=1, done=0, pass=0, status=LOAD, and all counts, fail_pc and fail_idx to 0, including mid-RUN.
REQ-028 Table contents SHALL be don't-care after reset.

Structure
REQ-029 Package mips_check_pkg SHALL hold the state enum (3-bit, LOAD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4) and the default parameter constants.
REQ-030 The table SHALL be a sub-module, store_exp_table (DEPTH x (ADDR_W+DATA_W), 1 write port, 1 combinational read port).

Verification
REQ-031 Load (0x54,0x7),(0x50,0x7); start; drive stores matching in order -> done=1, pass=1, match_count=2.
REQ-032 Load (0x54,0x7); drive store (0x54,0x8) at pc=0x3C -> FAIL, fail_idx=0, fail_pc=0x3C.
REQ-033 TIMEOUT=16, one entry, no memwrite -> TIMEOUT after 16 RUN cycles, cycle_count=16.
REQ-034 Load 9 entries with DEPTH=8 -> ld_ready=0 after 8 loads and the 9th is ignored; start with 0 entries -> PASS next cycle.
REQ-035 Assert reset mid-RUN after 1 match -> status=LOAD and all counts 0 asynchronously.
REQ-036 After PASS, assert start and replay the stores -> RUN with counts cleared, then PASS again.
